// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types, LFSR constants and flit packing for the NoC traffic generator
package traffic_pkg;
  localparam int ID_WIDTH = 8;
  localparam int MAX_WIDTH = 64;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
  function automatic logic [MAX_WIDTH-1:0] pack_flit(input int aw, input int dw,
      input logic [MAX_WIDTH-1:0] src, input logic [MAX_WIDTH-1:0] dst,
      input logic [MAX_WIDTH-1:0] id, input logic [MAX_WIDTH-1:0] seq);
    logic [MAX_WIDTH-1:0] am, dm;
    am = (64'd1 << aw) - 64'd1;
    dm = (64'd1 << dw) - 64'd1;
    return ((src & am) << (aw + ID_WIDTH + dw)) | ((dst & am) << (ID_WIDTH + dw)) |
           ((id & 64'hFF) << dw) | (seq & dm);
  endfunction
endpackage

// File: rtl/traffic_lfsr.sv
// traffic_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) stepping once per advance
// Ports: clk, rst (async, active-high), advance (step enable), state (current LFSR value)
module traffic_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [15:0] state
);
  import traffic_pkg::*;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= SEED;
    else if (advance) state <= lfsr_step(state);
endmodule

// File: rtl/traffic_gen.sv
// traffic_gen: synthetic NoC flit source {src,dst,id,seq} with valid/ready, gap and packet budget
// Ports: clk, rst (async, active-high), enable, done (sticky), data_out, valid_out, ready_in,
//        sent_count (saturating transfer count)
// Macro TRAFFIC_GEN_RANDOM_DST_EN: pseudo-random destination from an LFSR instead of DEST.
module traffic_gen #(
  parameter int         WIDTH        = 32,
  parameter int         N            = 16,
  parameter int         N_ADDR_WIDTH = $clog2(N),
  parameter logic [7:0] ID           = 8'd0,
  parameter int         NODE         = 0,
  parameter int         DEST         = N - 1,
  parameter int         GAP          = 0,
  parameter int         NUM_PKTS     = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [31:0]      sent_count
);
  import traffic_pkg::*;
  localparam int DW = WIDTH - 2 * N_ADDR_WIDTH - ID_WIDTH;
  if (DW < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("traffic_gen: WIDTH leaves no room for seq or exceeds MAX_WIDTH");
  end
  state_t                  state;
  logic [DW-1:0]           seq;
  logic [31:0]             gap_cnt;
  logic [N_ADDR_WIDTH-1:0] dst_cur, dst_nxt;
  logic                    last;
  assign last = NUM_PKTS != 0 && {1'b0, sent_count} + 33'd1 == 33'(NUM_PKTS);
  function automatic logic [WIDTH-1:0] flit(input logic [DW-1:0] s, input logic [N_ADDR_WIDTH-1:0] d);
    return WIDTH'(pack_flit(N_ADDR_WIDTH, DW, 64'(NODE), 64'(d), 64'(ID), 64'(s)));
  endfunction
`ifdef TRAFFIC_GEN_RANDOM_DST_EN
  logic [15:0] lfsr;
  function automatic logic [N_ADDR_WIDTH-1:0] pick(input logic [15:0] s);
    int v;
    v = int'(s[N_ADDR_WIDTH-1:0]) % N;
    v = (v == NODE) ? (NODE + 1) % N : v;
    return N_ADDR_WIDTH'(v);
  endfunction
  traffic_lfsr #(.SEED(LFSR_SEED ^ 16'(ID))) u_lfsr (
    .clk(clk), .rst(rst), .advance(valid_out & ready_in), .state(lfsr)
  );
  // back-to-back flits are formed at the transfer edge, so they need the post-step LFSR value
  assign dst_cur = pick(lfsr);
  assign dst_nxt = pick(lfsr_step(lfsr));
`else
  assign dst_cur = N_ADDR_WIDTH'(DEST);
  assign dst_nxt = dst_cur;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      valid_out  <= 1'b0;
      data_out   <= '0;
      done       <= 1'b0;
      sent_count <= '0;
      seq        <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (enable) begin
          state     <= SEND;
          valid_out <= 1'b1;
          data_out  <= flit(seq, dst_cur);
        end
        SEND: if (ready_in) begin
          seq <= seq + 1'b1;
          if (sent_count != '1) sent_count <= sent_count + 32'd1;
          if (last) begin
            state     <= DONE;
            valid_out <= 1'b0;
            done      <= 1'b1;
          end else if (!enable) begin
            state     <= IDLE;
            valid_out <= 1'b0;
          end else if (GAP > 0) begin
            state     <= traffic_pkg::GAP;
            valid_out <= 1'b0;
            gap_cnt   <= 32'(GAP);
          end else data_out <= flit(seq + 1'b1, dst_nxt);
        end
        traffic_pkg::GAP:
          if (!enable) state <= IDLE;
          else if (gap_cnt == 32'd1) begin
            state     <= SEND;
            valid_out <= 1'b1;
            data_out  <= flit(seq, dst_cur);
          end else gap_cnt <= gap_cnt - 32'd1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_traffic_gen.sv
// tb_traffic_gen: directed, table-driven checks of traffic_gen across several parameter sets
module tb_traffic_gen;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic en0 = 0, rdy0 = 0, v0, dn0; logic [31:0] d0, s0;
  logic en1 = 0, rdy1 = 0, v1, dn1; logic [31:0] d1, s1;
  logic en2 = 0, rdy2 = 0, v2, dn2; logic [31:0] d2, s2;
  logic en3 = 0, rdy3 = 0, v3, dn3; logic [23:0] d3; logic [31:0] s3;
  int n_cmp = 0, n_bad = 0;

  traffic_gen #(.NUM_PKTS(4)) u0 (.clk(clk), .rst(rst), .enable(en0), .done(dn0),
    .data_out(d0), .valid_out(v0), .ready_in(rdy0), .sent_count(s0));
  traffic_gen #(.NUM_PKTS(0)) u1 (.clk(clk), .rst(rst), .enable(en1), .done(dn1),
    .data_out(d1), .valid_out(v1), .ready_in(rdy1), .sent_count(s1));
  traffic_gen #(.GAP(3), .NUM_PKTS(0)) u2 (.clk(clk), .rst(rst), .enable(en2), .done(dn2),
    .data_out(d2), .valid_out(v2), .ready_in(rdy2), .sent_count(s2));
  traffic_gen #(.WIDTH(24), .NUM_PKTS(0)) u3 (.clk(clk), .rst(rst), .enable(en3), .done(dn3),
    .data_out(d3), .valid_out(v3), .ready_in(rdy3), .sent_count(s3));
`ifdef TRAFFIC_GEN_RANDOM_DST_EN
  logic en4 = 0, rdy4 = 0, v4, dn4; logic [31:0] d4, s4;
  traffic_gen #(.NODE(5), .ID(8'h3C), .NUM_PKTS(0)) u4 (.clk(clk), .rst(rst), .enable(en4),
    .done(dn4), .data_out(d4), .valid_out(v4), .ready_in(rdy4), .sent_count(s4));
`endif

  typedef struct {
    logic en, rdy, v, dn;
    logic [31:0] d, s;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0F000000, 32'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0F000001, 32'd1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0F000002, 32'd2};
    for (int i = 3; i < 8; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0F000002, 32'd2};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0F000002, 32'd2};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0F000003, 32'd3};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'd4};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'd4};
    #12;
    chk("reset valid", 64'(v0), 0);
    chk("reset data", 64'(d0), 0);
    chk("reset done", 64'(dn0), 0);
    chk("reset sent", 64'(s0), 0);
    rst = 1'b0;
    // budget of 4 with a backpressure stall in the middle
    for (int i = 0; i < 12; i++) begin
      en0 = tbl[i].en;
      rdy0 = tbl[i].rdy;
      step;
      chk($sformatf("tbl[%0d] valid", i), 64'(v0), 64'(tbl[i].v));
      chk($sformatf("tbl[%0d] done", i), 64'(dn0), 64'(tbl[i].dn));
      chk($sformatf("tbl[%0d] sent", i), 64'(s0), 64'(tbl[i].s));
      if (tbl[i].v) chk($sformatf("tbl[%0d] data", i), 64'(d0), 64'(tbl[i].d));
    end
    en0 = 1'b0;
    // enable drop in SEND returns to IDLE after the transfer; seq is kept
    en1 = 1'b1; rdy1 = 1'b1;
    step; chk("u1 first data", 64'(d1), 64'h0F000000); chk("u1 first valid", 64'(v1), 1);
    step; chk("u1 b2b data", 64'(d1), 64'h0F000001);
    step; chk("u1 b2b sent", 64'(s1), 2);
    en1 = 1'b0;
    step; chk("u1 idle valid", 64'(v1), 0); chk("u1 idle sent", 64'(s1), 3);
    step; chk("u1 idle hold", 64'(v1), 0);
    en1 = 1'b1;
    step; chk("u1 resume data", 64'(d1), 64'h0F000003); chk("u1 resume valid", 64'(v1), 1);
    rdy1 = 1'b0;
    // GAP=3: valid flits exactly 4 cycles apart
    begin
      int ntx, last_c;
      ntx = 0; last_c = 0;
      en2 = 1'b1; rdy2 = 1'b1;
      for (int c = 0; c < 400 && ntx < 50; c++) begin
        step;
        if (v2) begin
          if (ntx > 0) chk("gap spacing", 64'(c - last_c), 4);
          chk("gap seq", 64'(d2), 64'h0F000000 | 64'(ntx));
          chk("gap done", 64'(dn2), 0);
          last_c = c;
          ntx++;
        end
      end
      chk("gap count", 64'(ntx), 50);
      en2 = 1'b0;
      step; chk("gap final sent", 64'(s2), 50); chk("gap final valid", 64'(v2), 0);
    end
    // 8-bit seq wraps on the 257th transfer
    en3 = 1'b1; rdy3 = 1'b1;
    for (int k = 1; k <= 258; k++) begin
      step;
      chk("wrap data", 64'(d3), {40'h0, 8'h0F, 8'h00, 8'(k - 1)});
      chk("wrap sent", 64'(s3), 64'(k - 1));
    end
    chk("wrap done", 64'(dn3), 0);
    en3 = 1'b0; rdy3 = 1'b0;
    // asynchronous reset between edges while u1 is presenting and u0 is done
    #3 rst = 1'b1;
    #1;
    chk("async valid", 64'(v1), 0);
    chk("async done", 64'(dn0), 0);
    chk("async done u1", 64'(dn1), 0);
    chk("async sent", 64'(s1), 0);
    rst = 1'b0;
    en1 = 1'b1; rdy1 = 1'b1;
    step; chk("post-reset data", 64'(d1), 64'h0F000000); chk("post-reset valid", 64'(v1), 1);
    step; chk("post-reset next", 64'(d1), 64'h0F000001);
    en1 = 1'b0; rdy1 = 1'b0;
`ifdef TRAFFIC_GEN_RANDOM_DST_EN
    begin
      logic [3:0] rec[200];
      logic [15:0] lf;
      logic [3:0] e;
      for (int pass = 0; pass < 2; pass++) begin
        int n;
        n = 0;
        rst = 1'b1; #2 rst = 1'b0;
        en4 = 1'b1; rdy4 = 1'b1;
        lf = 16'hACE1 ^ 16'h003C;
        for (int c = 0; c < 400 && n < 200; c++) begin
          step;
          if (v4) begin
            e = lf[3:0];
            if (e == 4'd5) e = 4'd6;
            chk("rnd dst model", 64'(d4[27:24]), 64'(e));
            chk("rnd dst not node", 64'(d4[27:24] != 4'd5 && d4[31:28] == 4'd5), 1);
            if (pass == 1) chk("rnd repeat", 64'(d4[27:24]), 64'(rec[n]));
            else rec[n] = d4[27:24];
            lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
            n++;
          end
        end
        chk("rnd count", 64'(n), 200);
        en4 = 1'b0;
        step; chk("rnd done", 64'(dn4), 0); chk("rnd sent", 64'(s4), 200);
      end
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
